// File: rtl/alarm_pkg.sv
// alarm_pkg
//   Shared constants for the home-alarm sequencer: state codes, the default
//   interval lengths (in ticks) and the default interval counter width.
package alarm_pkg;

   localparam int ALARM_CW            = 8;
   localparam int EXIT_TICKS_DEFAULT  = 30;
   localparam int ENTRY_TICKS_DEFAULT = 15;
   localparam int SIREN_TICKS_DEFAULT = 180;

   localparam logic [2:0] ST_DISARMED    = 3'd0;
   localparam logic [2:0] ST_EXIT_DELAY  = 3'd1;
   localparam logic [2:0] ST_ARMED       = 3'd2;
   localparam logic [2:0] ST_ENTRY_DELAY = 3'd3;
   localparam logic [2:0] ST_ALARM       = 3'd4;

endpackage

// File: rtl/alarm_sequencer_if.sv
// alarm_sequencer_if
//   Groups the sequencer's event inputs and indicator outputs.
//   master : keypad/sensor side, drives tick, arm, disarm, sensor, instant, panic
//   slave  : the sequencer, drives state_o, siren, armed_led, beep, remaining
interface alarm_sequencer_if #(
   parameter int CW = 8
);
   logic          tick;
   logic          arm;
   logic          disarm;
   logic          sensor;
   logic          instant;
   logic          panic;
   logic [2:0]    state_o;
   logic          siren;
   logic          armed_led;
   logic          beep;
   logic [CW-1:0] remaining;

   modport master (
      output tick, arm, disarm, sensor, instant, panic,
      input  state_o, siren, armed_led, beep, remaining
   );

   modport slave (
      input  tick, arm, disarm, sensor, instant, panic,
      output state_o, siren, armed_led, beep, remaining
   );
endinterface

// File: rtl/interval_counter.sv
// interval_counter
//   Reloadable tick down-counter shared by every timed alarm interval.
//   clkSignal, RST    : clock, async active-high reset
//   load_i/load_value_i : load has priority; a tick in the load cycle is ignored
//   tick_i            : decrement strobe, saturates at 0
//   count_o           : current count
//   expire_o          : terminal count, tick while count==1
module interval_counter #(
   parameter int CW = 8
) (
   input  logic          clkSignal,
   input  logic          RST,
   input  logic          load_i,
   input  logic [CW-1:0] load_value_i,
   input  logic          tick_i,
   output logic [CW-1:0] count_o,
   output logic          expire_o
);

   logic [CW-1:0] count_q;
   logic [CW-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (load_i) begin
         count_d = load_value_i;
      end else if (tick_i && (count_q != '0)) begin
         count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge clkSignal or posedge RST) begin
      if (RST) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o  = count_q;
   assign expire_o = tick_i && (count_q == CW'(1));

endmodule

// File: rtl/alarm_sequencer.sv
// alarm_sequencer
//   Central state machine of the home-alarm module: exit delay, entry delay
//   and siren duration, all timed from one interval_counter.
//   clkSignal, RST : clock, async active-high reset
//   sq_if (slave)  : tick/arm/disarm/panic strobes, sensor/instant levels in;
//                    state_o, siren, armed_led, beep, remaining out (registered)
//
//   state          | meaning
//   DISARMED    0  | idle, waiting for arm
//   EXIT_DELAY  1  | arming, occupants leaving, beeper on
//   ARMED       2  | watching zones
//   ENTRY_DELAY 3  | door opened, waiting for disarm, beeper on
//   ALARM       4  | siren sounding, auto-rearm on expiry
//   5..7           | illegal, forced back to DISARMED
module alarm_sequencer
   import alarm_pkg::*;
#(
   parameter int CW          = ALARM_CW,
   parameter int EXIT_TICKS  = EXIT_TICKS_DEFAULT,
   parameter int ENTRY_TICKS = ENTRY_TICKS_DEFAULT,
   parameter int SIREN_TICKS = SIREN_TICKS_DEFAULT
) (
   input  logic              clkSignal,
   input  logic              RST,
   alarm_sequencer_if.slave  sq_if
);

   if (EXIT_TICKS < 1 || EXIT_TICKS > (1 << CW) - 1) begin : g_bad_exit
      $error("alarm_sequencer: EXIT_TICKS out of range");
   end
   if (ENTRY_TICKS < 1 || ENTRY_TICKS > (1 << CW) - 1) begin : g_bad_entry
      $error("alarm_sequencer: ENTRY_TICKS out of range");
   end
   if (SIREN_TICKS < 1 || SIREN_TICKS > (1 << CW) - 1) begin : g_bad_siren
      $error("alarm_sequencer: SIREN_TICKS out of range");
   end

   logic [2:0]    state_q, state_d;
   logic          siren_q, siren_d;
   logic          led_q, led_d;
   logic          beep_q, beep_d;
   logic          load;
   logic [CW-1:0] load_value;
   logic [CW-1:0] count;
   logic          expire;
   logic          count_tick;

   interval_counter #(.CW(CW)) u_interval_counter (
      .clkSignal    (clkSignal),
      .RST          (RST),
      .load_i       (load),
      .load_value_i (load_value),
      .tick_i       (sq_if.tick),
      .count_o      (count),
      .expire_o     (expire)
   );

   // Every event that fires also reloads the counter, including panic while
   // already in ALARM, which restarts the siren interval.
   always_comb begin
      state_d = state_q;
      load    = 1'b0;
      case (state_q)
         ST_DISARMED, ST_EXIT_DELAY, ST_ARMED, ST_ENTRY_DELAY, ST_ALARM: begin
            if (sq_if.disarm) begin
               state_d = ST_DISARMED;
               load    = 1'b1;
            end else if (sq_if.panic) begin
               state_d = ST_ALARM;
               load    = 1'b1;
            end else if (sq_if.instant &&
                         (state_q == ST_ARMED || state_q == ST_ENTRY_DELAY)) begin
               state_d = ST_ALARM;
               load    = 1'b1;
            end else if (expire && state_q == ST_EXIT_DELAY) begin
               state_d = ST_ARMED;
               load    = 1'b1;
            end else if (expire && state_q == ST_ENTRY_DELAY) begin
               state_d = ST_ALARM;
               load    = 1'b1;
            end else if (expire && state_q == ST_ALARM) begin
               state_d = ST_ARMED;
               load    = 1'b1;
            end else if (sq_if.sensor && state_q == ST_ARMED) begin
               state_d = ST_ENTRY_DELAY;
               load    = 1'b1;
            end else if (sq_if.arm && state_q == ST_DISARMED) begin
               state_d = ST_EXIT_DELAY;
               load    = 1'b1;
            end
         end
         default: begin
            state_d = ST_DISARMED;
            load    = 1'b1;
         end
      endcase
   end

   always_comb begin
      case (state_d)
         ST_EXIT_DELAY:  load_value = CW'(EXIT_TICKS);
         ST_ENTRY_DELAY: load_value = CW'(ENTRY_TICKS);
         ST_ALARM:       load_value = CW'(SIREN_TICKS);
         default:        load_value = '0;
      endcase
   end

   // Outputs are computed from the next state so the registers show the
   // state being entered on the same edge.
   assign count_tick = sq_if.tick && !load &&
                       (state_q == ST_EXIT_DELAY || state_q == ST_ENTRY_DELAY);

   always_comb begin
      siren_d = (state_d == ST_ALARM);
      led_d   = (state_d == ST_ARMED) || (state_d == ST_ENTRY_DELAY) ||
                (state_d == ST_ALARM);
      beep_d  = beep_q;
      if (load) begin
         beep_d = 1'b0;
      end else if (count_tick) begin
         beep_d = ~beep_q;
      end
   end

   always_ff @(posedge clkSignal or posedge RST) begin
      if (RST) begin
         state_q <= ST_DISARMED;
         siren_q <= 1'b0;
         led_q   <= 1'b0;
         beep_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         siren_q <= siren_d;
         led_q   <= led_d;
         beep_q  <= beep_d;
      end
   end

   assign sq_if.state_o   = state_q;
   assign sq_if.siren     = siren_q;
   assign sq_if.armed_led = led_q;
   assign sq_if.beep      = beep_q;
   assign sq_if.remaining = count;

endmodule
